// File: rtl/fd_queue.sv
// Fetch-to-decode buffer: a small circular FIFO of {instr, PC, PC+4}
// between fetch and decode. It shows a zero bubble at the head whenever it
// is empty or being flushed.
module fd_queue #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arm,
  input  logic            validF,
  input  logic [XLEN-1:0] RDF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  output logic            readyF,
  input  logic            stallD,
  input  logic            flushD,
  output logic            validD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [XLEN-1:0] PCPlus8D,
  output logic [CW-1:0]   countD
);

  // A pointer is at least one bit wide. With DEPTH=1 it stays at 0.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } ent_t;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  ent_t          head;
  logic          push, pop, show;

  // readyF depends only on registered count and flushD. stallD never reaches it.
  assign readyF = (count != CW'(DEPTH)) && !flushD;
  assign validD = (count != '0);
  assign push   = validF && readyF;
  assign pop    = validD && !stallD && !flushD;
  assign countD = count;

  // Storage has no reset. An empty count is enough to hide stale contents.
  generate
    if (DEPTH == 1) begin : g_one
      ent_t mem;
      // Single entry: both pointers are fixed, so write straight into it.
      always_ff @(posedge clk) begin
        if (push) mem <= '{RDF, PCF, PCPlus4F};
      end
      assign head = mem;
    end else begin : g_many
      ent_t mem [DEPTH];
      // Write the fetched entry at the tail.
      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{RDF, PCF, PCPlus4F};
      end
      assign head = mem[rd_ptr];
    end
  endgenerate

  // Update pointers and occupancy. Flush overrides push, pop and stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flushD) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head outputs. Show a zero bubble when the buffer is empty or flushing.
  // Because this is combinational on count, a reset clears it at once.
  assign show     = validD && !flushD;
  assign InstrD   = show ? head.instr : '0;
  assign PCD      = show ? head.pc    : '0;
  assign PCPlus4D = show ? head.pc4   : '0;
  assign PCPlus8D = arm ? PCPlus4D + XLEN'(4) : PCPlus4D;

endmodule

// File: tb/tb_fd_queue.sv
// Scoreboard bench for fd_queue (DEPTH=2). Each accepted push goes into a
// model queue. Every cycle the DUT head is checked against the model head,
// and a pop removes that entry from the model.
module tb_fd_queue;
  localparam int XLEN = 32;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH + 1);

  logic            clk, rst_n, arm, validF, stallD, flushD;
  logic [XLEN-1:0] RDF, PCF, PCPlus4F;
  logic            readyF, validD;
  logic [XLEN-1:0] InstrD, PCD, PCPlus4D, PCPlus8D;
  logic [CW-1:0]   countD;

  fd_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .validF(validF), .RDF(RDF),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .readyF(readyF), .stallD(stallD),
    .flushD(flushD), .validD(validD), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .PCPlus8D(PCPlus8D), .countD(countD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  ent_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic st, input logic fl);
    validF   = v;
    RDF      = ins;
    PCF      = pc;
    PCPlus4F = pc + 32'd4;
    stallD   = st;
    flushD   = fl;
  endtask

  // Check the DUT against the model, advance the model, then clock once.
  task automatic cycle();
    ent_t        h;
    logic [31:0] e8;
    bit          push, pop;
    #1;
    chk("validD", validD, q.size() != 0);
    chk("readyF", readyF, (q.size() != DEPTH) && !flushD);
    chk("countD", countD, q.size());
    if (q.size() != 0 && !flushD) begin
      h  = q[0];
      e8 = arm ? h.pc4 + 32'd4 : h.pc4;
      chk("InstrD", InstrD, h.ins);
      chk("PCD", PCD, h.pc);
      chk("PCPlus4D", PCPlus4D, h.pc4);
      chk("PCPlus8D", PCPlus8D, e8);
    end else begin
      chk("InstrD_bubble", InstrD, 32'd0);
      chk("PCD_bubble", PCD, 32'd0);
      chk("PCPlus4D_bubble", PCPlus4D, 32'd0);
    end
    push = validF && (q.size() < DEPTH) && !flushD;
    pop  = (q.size() != 0) && !stallD && !flushD;
    if (flushD) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{RDF, PCF, PCPlus4F});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    arm   = 1'b0;
    drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #3;
    chk("rst_validD", validD, 32'd0);
    chk("rst_InstrD", InstrD, 32'd0);
    chk("rst_countD", countD, 32'd0);
    chk("rst_readyF", readyF, 32'd1);
    chk("rst_PCPlus8D_rv", PCPlus8D, 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push while stalled, then let decode take it.
    drv(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    cycle();
    drv(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("push_PCPlus8D", PCPlus8D, 32'h104);
    cycle();
    stallD = 1'b0;
    cycle();

    // Fill under stall. The third push must be refused.
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 32'hA000 + i, 32'(i * 4), 1'b1, 1'b0);
      cycle();
    end
    chk("full_readyF", readyF, 32'd0);
    chk("full_count", countD, 32'd2);
    drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();

    // Push and pop together at count 1, continuing past the pointer wrap.
    drv(1'b1, 32'hB010, 32'h10, 1'b1, 1'b0);
    cycle();
    for (int i = 1; i <= 6; i++) begin
      drv(1'b1, 32'hB010 + i, 32'h10 + 32'(i * 4), 1'b0, 1'b0);
      cycle();
      chk("pp_count", countD, 32'd1);
    end
    drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    cycle();

    // Flush takes priority over a simultaneous push and stall.
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 32'hC000 + i, 32'h200 + 32'(i * 4), 1'b1, 1'b0);
      cycle();
    end
    drv(1'b1, 32'hC0FF, 32'h2FC, 1'b1, 1'b1);
    cycle();
    drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("flush_count", countD, 32'd0);
    cycle();

    // ARM r15 value, including the 32-bit wrap.
    arm = 1'b1;
    drv(1'b1, 32'hE3A00001, 32'h8000, 1'b1, 1'b0);
    cycle();
    drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("arm_PCPlus8D", PCPlus8D, 32'h8008);
    cycle();
    drv(1'b1, 32'hE3A00002, 32'hFFFFFFF8, 1'b1, 1'b0);
    cycle();
    drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("arm_wrap_PCPlus8D", PCPlus8D, 32'h0);
    cycle();
    arm = 1'b0;

    // Reset asserted between clock edges must clear the outputs at once.
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 32'hD000 + i, 32'h300 + 32'(i * 4), 1'b1, 1'b0);
      cycle();
    end
    drv(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    #1;
    chk("pre_arst_count", countD, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_validD", validD, 32'd0);
    chk("arst_countD", countD, 32'd0);
    chk("arst_InstrD", InstrD, 32'd0);
    chk("arst_readyF", readyF, 32'd1);
    q.delete();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random mix of traffic, stalls, flushes and ISA mode.
    for (int i = 0; i < 80; i++) begin
      drv(1'($urandom_range(0, 1)), $urandom, $urandom,
          $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      arm = 1'($urandom_range(0, 1));
      cycle();
    end
    drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
